// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets several requesters share one
// UART transmitter (tx_wrapper). A word is captured on the grant edge. The
// arbiter then waits for the transmitter to go busy, and then waits for it
// to go idle again. If the transmitter never starts, a sticky timeout flag
// is raised.
module uart_tx_arbiter #(
  parameter int NO_OF_REQUESTERS = 4,
  parameter int NO_OF_DATA_BITS  = 8,
  parameter int BUSY_TIMEOUT     = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NO_OF_REQUESTERS-1:0]                 req_valid,
  input  logic [NO_OF_REQUESTERS*NO_OF_DATA_BITS-1:0] req_data,
  output logic [NO_OF_REQUESTERS-1:0]                 req_ack,
  input  logic                                        tx_busy,
  output logic [NO_OF_DATA_BITS-1:0]                  tx_word,
  output logic                                        tx_wr_enable,
  output logic [2:0]                                  grant_id,
  output logic                                        arb_busy,
  output logic                                        timeout_err
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_BUSY = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  localparam logic [7:0] TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);
  localparam logic [2:0] LAST_RESET   = 3'(NO_OF_REQUESTERS - 1);
  localparam logic [NO_OF_REQUESTERS-1:0] ONE_HOT0 = {{(NO_OF_REQUESTERS-1){1'b0}}, 1'b1};
  localparam logic [NO_OF_REQUESTERS-1:0] NO_REQ   = {NO_OF_REQUESTERS{1'b0}};

  logic [1:0]                        state_q, state_d;
  logic [7:0]                        cnt_q, cnt_d;
  logic [2:0]                        last_q, last_d;
  logic [NO_OF_REQUESTERS-1:0]       ack_q, ack_d;
  logic                              wr_q, wr_d;
  logic [NO_OF_DATA_BITS-1:0]        word_q, word_d;
  logic [2:0]                        gid_q, gid_d;
  logic                              abusy_q, abusy_d;
  logic                              terr_q, terr_d;

  logic [2:0]                                  winner_s;
  logic [NO_OF_REQUESTERS*NO_OF_DATA_BITS-1:0] data_shift_s;
  logic [NO_OF_DATA_BITS-1:0]                  win_word_s;

  // Round-robin pick: search starts at the requester after the last grant
  // and wraps around. The last granted requester has the lowest priority.
  function automatic logic [2:0] rr_pick(input logic [NO_OF_REQUESTERS-1:0] valid,
                                         input logic [2:0] last);
    logic [2:0]                  win;
    logic                        found;
    logic [NO_OF_REQUESTERS-1:0] shifted;
    int                          idx;
    win   = 3'd0;
    found = 1'b0;
    for (int k = 1; k <= NO_OF_REQUESTERS; k++) begin
      idx     = (int'(last) + k) % NO_OF_REQUESTERS;
      shifted = valid >> idx;
      if (!found && shifted[0]) begin
        win   = 3'(idx);
        found = 1'b1;
      end else begin
        win   = win;
      end
    end
    return win;
  endfunction

  // Winner index and its word, evaluated every cycle and used only in IDLE
  always_comb begin
    winner_s     = rr_pick(req_valid, last_q);
    data_shift_s = req_data >> (int'(winner_s) * NO_OF_DATA_BITS);
    win_word_s   = data_shift_s[NO_OF_DATA_BITS-1:0];
  end

  // Next-state and next-output logic for the arbitration FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ack_d   = NO_REQ;
    wr_d    = 1'b0;
    word_d  = word_q;
    gid_d   = gid_q;
    terr_d  = terr_q;
    case (state_q)
      IDLE: begin
        if ((req_valid != NO_REQ) && !tx_busy) begin
          state_d = WAIT_BUSY;
          cnt_d   = 8'd0;
          last_d  = winner_s;
          gid_d   = winner_s;
          word_d  = win_word_s;
          ack_d   = ONE_HOT0 << winner_s;
          wr_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    abusy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset is synchronous and active-low
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      last_q  <= LAST_RESET;
      ack_q   <= NO_REQ;
      wr_q    <= 1'b0;
      word_q  <= {NO_OF_DATA_BITS{1'b0}};
      gid_q   <= 3'd0;
      abusy_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      gid_q   <= gid_d;
      abusy_q <= abusy_d;
      terr_q  <= terr_d;
    end
  end

  assign req_ack      = ack_q;
  assign tx_wr_enable = wr_q;
  assign tx_word      = word_q;
  assign grant_id     = gid_q;
  assign arb_busy     = abusy_q;
  assign timeout_err  = terr_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NO_OF_REQUESTERS, default 4, number of requesters sharing one tx_wrapper instance; legal range 2-8.
REQ-002 Parameter NO_OF_DATA_BITS, default 8, word width per requester; legal values 6, 7, 8; must equal the tx_wrapper setting.
REQ-003 Parameter BUSY_TIMEOUT, default 16, clock cycles allowed for tx_busy to rise after a write; legal range 2-255.
REQ-004 clk  input  1  system clock; all logic is rising-edge.
REQ-005 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 req_valid  input  NO_OF_REQUESTERS  bit i high means requester i holds a word to send.
REQ-007 req_data  input  NO_OF_REQUESTERS*NO_OF_DATA_BITS  word i occupies bits [i*NO_OF_DATA_BITS +: NO_OF_DATA_BITS].
REQ-008 req_ack  output  NO_OF_REQUESTERS  one-cycle pulse on bit i when word i has been captured.
REQ-009 tx_busy  input  1  driven by the tx_wrapper tx_busy output.
REQ-010 tx_word  output  NO_OF_DATA_BITS  drives tx_wrapper data_parallel_in.
REQ-011 tx_wr_enable  output  1  drives tx_wrapper data_parallel_wr_enable; one-cycle pulse.
REQ-012 grant_id  output  3  index of the requester most recently granted.
REQ-013 arb_busy  output  1  high in every state except IDLE.
REQ-014 timeout_err  output  1  sticky flag; set when tx_busy fails to rise within BUSY_TIMEOUT cycles.

Function
REQ-015 FSM states: IDLE, WAIT_BUSY, WAIT_DONE; all outputs are registered.
REQ-016 In IDLE, a grant is decided only when req_valid is not zero and tx_busy is 0; otherwise the FSM stays in IDLE.
REQ-017 Winner selection is round-robin: priority order is last_grant+1, last_grant+2, ... modulo NO_OF_REQUESTERS.
REQ-018 On the grant edge, the FSM registers the winner's word into tx_word, the winner's index into grant_id and into last_grant, and sets req_ack[winner] and tx_wr_enable to 1 for exactly one cycle; it then moves to WAIT_BUSY.
REQ-019 Latency: req_valid sampled high in IDLE causes req_ack and tx_wr_enable to be high in the following cycle; no other req_ack bit is set in that cycle.
REQ-020 tx_word holds its value until the next grant.
REQ-021 WAIT_BUSY: a cycle counter counts from 0 on entry; tx_busy=1 moves the FSM to WAIT_DONE.
REQ-022 WAIT_BUSY: if the counter reaches BUSY_TIMEOUT-1 with tx_busy still 0, timeout_err is set and the FSM moves to IDLE.
REQ-023 WAIT_DONE: tx_busy=0 moves the FSM to IDLE; there is no timeout in this state.
REQ-024 req_valid and req_data are ignored outside IDLE.
REQ-025 A requester that still holds req_valid after its ack makes a new request, which is arbitrated normally.
REQ-026 A request withdrawn before its grant is dropped without any ack.
REQ-027 A single persistent requester is re-granted back-to-back; between grants it waits only for the tx_busy fall plus one IDLE cycle.
REQ-028 timeout_err is cleared only by reset.

Reset
REQ-029 While reset=0 at a clock edge, the following values are forced and held: state=IDLE, req_ack=0, tx_wr_enable=0, tx_word=0, grant_id=0, arb_busy=0, timeout_err=0, counter=0, last_grant=NO_OF_REQUESTERS-1.
REQ-030 Reset asserted in the middle of a transfer abandons the transfer with no ack and no further write pulse; the first grant after reset goes to the lowest-indexed valid requester.

Verification
REQ-031 Reset, then req_valid=4'b0001 with req_data[7:0]=8'hA5 -> one cycle later req_ack=4'b0001, tx_wr_enable=1, tx_word=8'hA5, grant_id=0; tx_data serialises 8'hA5 LSB first at BAUD.
REQ-032 req_valid=4'b1111 held for 8 words -> grant_id sequence 0,1,2,3,0,1,2,3; exactly one ack per word; no tx_wr_enable while tx_busy=1.
REQ-033 tx_busy tied to 0, single request -> timeout_err=1 exactly BUSY_TIMEOUT cycles after the write pulse; FSM back in IDLE; next request is still granted.
REQ-034 req_valid=4'b0101 while in WAIT_DONE, where last_grant=2 -> next grant goes to requester 0, then to requester 2.
REQ-035 reset=0 driven during WAIT_DONE -> all outputs at reset values on the next edge; after release, req_valid=4'b1000 is granted to requester 3.
REQ-036 req_valid[1] pulsed high for one cycle while in WAIT_BUSY -> no ack to requester 1 and no extra write.
